// File: rtl/mgmt_protect_pkg.sv
// rtl/mgmt_protect_pkg.sv - shared types, constants and helpers for the management protection layer
package mgmt_protect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ACK  = 2'd2
    } wb_guard_state_t;

    localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mgmt_sync_bit.sv
// rtl/mgmt_sync_bit.sv - multi-flop synchroniser for one asynchronous bit
module mgmt_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/mgmt_protect_wb_guard.sv
// rtl/mgmt_protect_wb_guard.sv - LA/IRQ gating plus a Wishbone guard that never lets the user stall management
module mgmt_protect_wb_guard
    import mgmt_protect_pkg::*;
#(
    parameter int          LA_WIDTH     = 64,
    parameter int          IRQ_COUNT    = 3,
    parameter int          SYNC_STAGES  = 2,
    parameter int          WB_TIMEOUT   = 255,
    parameter logic [31:0] TIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
    input  logic                 caravel_clk,
    input  logic                 caravel_rst,
    input  logic                 mprj_cyc_o_core,
    input  logic                 mprj_stb_o_core,
    input  logic                 mprj_we_o_core,
    input  logic [3:0]           mprj_sel_o_core,
    input  logic [31:0]          mprj_adr_o_core,
    input  logic [31:0]          mprj_dat_o_core,
    output logic [31:0]          mprj_dat_i_core,
    output logic                 mprj_ack_i_core,
    input  logic                 mprj_iena_wb,
    output logic                 mprj_cyc_o_user,
    output logic                 mprj_stb_o_user,
    output logic                 mprj_we_o_user,
    output logic [3:0]           mprj_sel_o_user,
    output logic [31:0]          mprj_adr_o_user,
    output logic [31:0]          mprj_dat_o_user,
    input  logic [31:0]          mprj_dat_i_user,
    input  logic                 mprj_ack_i_user,
    input  logic [LA_WIDTH-1:0]  la_data_out_core,
    input  logic [LA_WIDTH-1:0]  la_iena_mprj,
    output logic [LA_WIDTH-1:0]  la_data_in_mprj,
    input  logic [IRQ_COUNT-1:0] user_irq_core,
    input  logic [IRQ_COUNT-1:0] user_irq_ena,
    output logic [IRQ_COUNT-1:0] user_irq,
    output logic                 wb_timeout_flag,
    input  logic                 wb_timeout_clr
);

    localparam int             CNT_W    = clog2(WB_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WB_TIMEOUT - 1);

    wb_guard_state_t  state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      dat_r, dat_next;
    logic             flag_set;
    logic             ack_r;
    logic             fwd_r;
    logic             core_req;

    assign core_req = mprj_cyc_o_core & mprj_stb_o_core;

    // The enable is only consulted in IDLE, so flipping it mid-transaction is harmless.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dat_next   = dat_r;
        flag_set   = 1'b0;
        case (state)
            IDLE: begin
                if (core_req) begin
                    if (mprj_iena_wb) begin
                        state_next = FWD;
                        cnt_next   = '0;
                    end else begin
                        state_next = ACK;
                        dat_next   = 32'h0;
                    end
                end
            end
            FWD: begin
                if (!mprj_cyc_o_core) begin
                    state_next = IDLE;
                end else if (mprj_ack_i_user) begin
                    state_next = ACK;
                    dat_next   = mprj_dat_i_user;
                end else if (cnt == CNT_LAST) begin
                    state_next = ACK;
                    dat_next   = TIMEOUT_DATA;
                    flag_set   = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge caravel_clk or posedge caravel_rst) begin
        if (caravel_rst) begin
            state           <= IDLE;
            cnt             <= '0;
            dat_r           <= 32'h0;
            ack_r           <= 1'b0;
            fwd_r           <= 1'b0;
            wb_timeout_flag <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            dat_r           <= dat_next;
            ack_r           <= (state_next == ACK);
            fwd_r           <= (state_next == FWD);
            wb_timeout_flag <= flag_set | (wb_timeout_flag & ~wb_timeout_clr);
        end
    end

    assign mprj_ack_i_core = ack_r;
    assign mprj_dat_i_core = dat_r;
    assign mprj_cyc_o_user = fwd_r;
    assign mprj_stb_o_user = fwd_r;
    assign mprj_we_o_user  = mprj_we_o_core;
    assign mprj_sel_o_user = mprj_sel_o_core;
    assign mprj_adr_o_user = mprj_adr_o_core;
    assign mprj_dat_o_user = mprj_dat_o_core;

    logic [IRQ_COUNT-1:0] irq_synced;

    for (genvar i = 0; i < IRQ_COUNT; i++) begin : g_irq_sync
        mgmt_sync_bit #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk (caravel_clk),
            .rst (caravel_rst),
            .d   (user_irq_core[i]),
            .q   (irq_synced[i])
        );
    end

    always_ff @(posedge caravel_clk or posedge caravel_rst) begin
        if (caravel_rst) begin
            la_data_in_mprj <= '0;
            user_irq        <= '0;
        end else begin
            la_data_in_mprj <= la_data_out_core & la_iena_mprj;
            user_irq        <= irq_synced & user_irq_ena;
        end
    end

endmodule

// File: tb/tb_mgmt_protect_wb_guard.sv
// tb/tb_mgmt_protect_wb_guard.sv - self-checking bench for mgmt_protect_wb_guard
module tb_mgmt_protect_wb_guard;

    localparam int LAW  = 64;
    localparam int IRQN = 3;
    localparam int SYNC = 2;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cyc, stb, we, iena, ack_user, clr;
    logic [3:0]      sel;
    logic [31:0]     adr, dat_o, dat_user;
    logic [LAW-1:0]  la_out, la_iena;
    logic [IRQN-1:0] irq_raw, irq_ena;

    logic [31:0]     dat_core, adr_u, dat_o_u;
    logic            ack_core, cyc_u, stb_u, we_u, flag;
    logic [3:0]      sel_u;
    logic [LAW-1:0]  la_in;
    logic [IRQN-1:0] irq_out;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mgmt_protect_wb_guard #(
        .LA_WIDTH     (LAW),
        .IRQ_COUNT    (IRQN),
        .SYNC_STAGES  (SYNC),
        .WB_TIMEOUT   (TMO),
        .TIMEOUT_DATA (32'hDEADBEEF)
    ) dut (
        .caravel_clk      (clk),
        .caravel_rst      (rst),
        .mprj_cyc_o_core  (cyc),
        .mprj_stb_o_core  (stb),
        .mprj_we_o_core   (we),
        .mprj_sel_o_core  (sel),
        .mprj_adr_o_core  (adr),
        .mprj_dat_o_core  (dat_o),
        .mprj_dat_i_core  (dat_core),
        .mprj_ack_i_core  (ack_core),
        .mprj_iena_wb     (iena),
        .mprj_cyc_o_user  (cyc_u),
        .mprj_stb_o_user  (stb_u),
        .mprj_we_o_user   (we_u),
        .mprj_sel_o_user  (sel_u),
        .mprj_adr_o_user  (adr_u),
        .mprj_dat_o_user  (dat_o_u),
        .mprj_dat_i_user  (dat_user),
        .mprj_ack_i_user  (ack_user),
        .la_data_out_core (la_out),
        .la_iena_mprj     (la_iena),
        .la_data_in_mprj  (la_in),
        .user_irq_core    (irq_raw),
        .user_irq_ena     (irq_ena),
        .user_irq         (irq_out),
        .wb_timeout_flag  (flag),
        .wb_timeout_clr   (clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a request is either being forwarded (with an age in cycles) or being acked.
    bit              m_fwd = 0;
    bit              m_ack = 0;
    bit              m_flag = 0;
    bit              m_next_ack;
    bit              m_timeout;
    int              m_age = 0;
    logic [31:0]     m_dat = '0;
    logic [LAW-1:0]  m_la = '0;
    logic [IRQN-1:0] m_irq = '0;
    logic [IRQN-1:0] hist [0:SYNC];

    initial begin
        for (int i = 0; i <= SYNC; i++) hist[i] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_fwd = 0; m_ack = 0; m_flag = 0; m_age = 0;
                m_dat = '0; m_la = '0; m_irq = '0;
                for (int i = 0; i <= SYNC; i++) hist[i] = '0;
            end else begin
                m_la = la_out & la_iena;
                for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = irq_raw;
                m_irq = hist[SYNC] & irq_ena;
                m_next_ack = 0;
                m_timeout = 0;
                if (m_fwd) begin
                    if (!cyc) begin
                        m_fwd = 0;
                    end else if (ack_user) begin
                        m_fwd = 0; m_next_ack = 1; m_dat = dat_user;
                    end else if (m_age + 1 == TMO) begin
                        m_fwd = 0; m_next_ack = 1; m_dat = 32'hDEADBEEF; m_timeout = 1;
                    end else begin
                        m_age++;
                    end
                end else if (!m_ack && cyc && stb) begin
                    if (iena) begin
                        m_fwd = 1; m_age = 0;
                    end else begin
                        m_next_ack = 1; m_dat = 32'h0;
                    end
                end
                if (m_timeout) m_flag = 1;
                else if (clr) m_flag = 0;
                m_ack = m_next_ack;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("m_ack", 64'(ack_core), 64'(0));
                check("m_dat", 64'(dat_core), 64'(0));
                check("m_cyc", 64'(cyc_u), 64'(0));
                check("m_stb", 64'(stb_u), 64'(0));
                check("m_la", la_in, 64'(0));
                check("m_irq", 64'(irq_out), 64'(0));
                check("m_flag", 64'(flag), 64'(0));
            end else begin
                check("m_ack", 64'(ack_core), 64'(m_ack));
                check("m_dat", 64'(dat_core), 64'(m_dat));
                check("m_cyc", 64'(cyc_u), 64'(m_fwd));
                check("m_stb", 64'(stb_u), 64'(m_fwd));
                check("m_la", la_in, m_la);
                check("m_irq", 64'(irq_out), 64'(m_irq));
                check("m_flag", 64'(flag), 64'(m_flag));
            end
            check("m_we", 64'(we_u), 64'(we));
            check("m_sel", 64'(sel_u), 64'(sel));
            check("m_adr", 64'(adr_u), 64'(adr));
            check("m_dato", 64'(dat_o_u), 64'(dat_o));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int stb_cnt;
        bit seen;

        rst = 1'b1;
        cyc = 1'($urandom_range(0, 1)); stb = 1'($urandom_range(0, 1));
        we = 1'($urandom_range(0, 1)); iena = 1'($urandom_range(0, 1));
        ack_user = 1'($urandom_range(0, 1)); clr = 1'($urandom_range(0, 1));
        sel = 4'($urandom_range(0, 15)); adr = $urandom; dat_o = $urandom; dat_user = $urandom;
        la_out = {$urandom, $urandom}; la_iena = {$urandom, $urandom};
        irq_raw = 3'($urandom_range(0, 7)); irq_ena = 3'($urandom_range(0, 7));
        repeat (3) step();
        check("rst_ack", 64'(ack_core), 64'(0));
        check("rst_la", la_in, 64'(0));
        check("rst_irq", 64'(irq_out), 64'(0));
        check("rst_stb", 64'(stb_u), 64'(0));

        // LA gating after reset release
        cyc = 0; stb = 0; ack_user = 0; clr = 0; iena = 1;
        irq_raw = '0; irq_ena = '0;
        la_out = '1; la_iena = 64'h00FF_0000_0000_FFFF;
        rst = 1'b0;
        step();
        check("la_gate", la_in, 64'h00FF_0000_0000_FFFF);

        // Enabled read acked by the user three cycles after stb rises
        cyc = 1; stb = 1; we = 0; iena = 1; adr = 32'h3000_0004;
        step();
        check("rd_stb", 64'(stb_u), 64'(1));
        step();
        step();
        ack_user = 1; dat_user = 32'h1234_5678;
        step();
        ack_user = 0; dat_user = $urandom;
        check("rd_ack", 64'(ack_core), 64'(1));
        check("rd_dat", 64'(dat_core), 64'h1234_5678);
        cyc = 0; stb = 0;
        step();
        check("rd_ack_once", 64'(ack_core), 64'(0));
        check("rd_flag", 64'(flag), 64'(0));

        // Hung user: forced ack after TMO cycles of stb
        cyc = 1; stb = 1; stb_cnt = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack_core) begin
                seen = 1;
                break;
            end
            if (stb_u) stb_cnt++;
        end
        check("to_seen", 64'(seen), 64'(1));
        check("to_stb_cycles", 64'(stb_cnt), 64'(8));
        check("to_dat", 64'(dat_core), 64'hDEAD_BEEF);
        check("to_flag", 64'(flag), 64'(1));
        cyc = 0; stb = 0;
        step();
        check("to_flag_sticky", 64'(flag), 64'(1));
        clr = 1;
        step();
        clr = 0;
        check("to_flag_clr", 64'(flag), 64'(0));

        // Disabled user: immediate ack with zero data
        iena = 0; we = 1; dat_o = 32'hCAFE_F00D; cyc = 1; stb = 1;
        step();
        check("dis_cyc", 64'(cyc_u), 64'(0));
        check("dis_ack", 64'(ack_core), 64'(1));
        check("dis_dat", 64'(dat_core), 64'(0));
        cyc = 0; stb = 0;
        step();
        check("dis_ack_once", 64'(ack_core), 64'(0));

        // IRQ synchronisation latency and gating
        irq_ena = 3'b010;
        #2 irq_raw = 3'b010;
        step();
        check("irq_e1", 64'(irq_out), 64'(0));
        step();
        check("irq_e2", 64'(irq_out), 64'(0));
        step();
        check("irq_e3", 64'(irq_out), 64'(3'b010));
        irq_ena = 3'b000;
        step();
        check("irq_off", 64'(irq_out), 64'(0));
        irq_raw = '0;

        // User ack lands in the expiry cycle: user wins
        iena = 1; we = 0; cyc = 1; stb = 1;
        step();
        repeat (7) step();
        ack_user = 1; dat_user = 32'hA5A5_0F0F;
        step();
        ack_user = 0;
        check("race_ack", 64'(ack_core), 64'(1));
        check("race_dat", 64'(dat_core), 64'hA5A5_0F0F);
        check("race_flag", 64'(flag), 64'(0));
        cyc = 0; stb = 0;
        step();

        // Reset during forwarding drops the user strobe at once
        cyc = 1; stb = 1;
        step();
        step();
        check("abort_stb_pre", 64'(stb_u), 64'(1));
        rst = 1;
        #1;
        check("abort_cyc", 64'(cyc_u), 64'(0));
        check("abort_stb", 64'(stb_u), 64'(0));
        check("abort_ack", 64'(ack_core), 64'(0));
        step();
        cyc = 0; stb = 0;
        step();
        rst = 0;
        step();

        // Randomised traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            step();
            if (rst) rst = 0;
            else if ($urandom_range(0, 299) == 0) rst = 1;
            if (cyc && ack_core) begin
                cyc = 0; stb = 0;
            end else if (cyc && $urandom_range(0, 39) == 0) begin
                cyc = 0; stb = 0;
            end else if (!cyc && $urandom_range(0, 2) == 0) begin
                cyc = 1; stb = 1;
                we = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(0, 15));
                adr = $urandom; dat_o = $urandom;
            end
            if ($urandom_range(0, 3) == 0) iena = ($urandom_range(0, 3) != 0);
            ack_user = ($urandom_range(0, 4) == 0);
            dat_user = $urandom;
            la_out = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) la_iena = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) irq_ena = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 15) == 0);
            #2;
            if ($urandom_range(0, 3) == 0) irq_raw = 3'($urandom_range(0, 7));
        end
        rst = 0; cyc = 0; stb = 0; ack_user = 0; clr = 0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mgmt_protect_wb_guard.md
Name: mgmt_protect_wb_guard

Overview:
- Parametrised, clocked successor of the management-protection buffer layer. Sits between the management SoC and the user project area.
- Gates and registers LA inputs toward management, and synchronises and gates user IRQs.
- Adds a Wishbone guard FSM so a disabled, absent or hung user project can never stall the management bus. A stalled bus is answered with a timeout acknowledge and a sticky status flag.

Parameters:
- LA_WIDTH, 64, logic-analyzer bus width.
- IRQ_COUNT, 3, number of user IRQ lines.
- SYNC_STAGES, 2, flop stages on each user IRQ line (min 2).
- WB_TIMEOUT, 255, cycles in FWD without user ack before a forced ack (min 2, max 65535).
- TIMEOUT_DATA, 32'hDEADBEEF, read data returned on a timeout ack.

Ports:
- caravel_clk  in  1  single clock for all logic.
- caravel_rst  in  1  asynchronous, active-high reset.
- mprj_cyc_o_core  in  1  Wishbone cycle from management.
- mprj_stb_o_core  in  1  Wishbone strobe from management.
- mprj_we_o_core  in  1  write enable.
- mprj_sel_o_core  in  4  byte selects.
- mprj_adr_o_core  in  32  address.
- mprj_dat_o_core  in  32  write data.
- mprj_dat_i_core  out  32  read data to management.
- mprj_ack_i_core  out  1  ack to management.
- mprj_iena_wb  in  1  user Wishbone enable.
- mprj_cyc_o_user  out  1  cycle to user.
- mprj_stb_o_user  out  1  strobe to user.
- mprj_we_o_user  out  1  write enable to user.
- mprj_sel_o_user  out  4  byte selects to user.
- mprj_adr_o_user  out  32  address to user.
- mprj_dat_o_user  out  32  write data to user.
- mprj_dat_i_user  in  32  read data from user.
- mprj_ack_i_user  in  1  ack from user.
- la_data_out_core  in  LA_WIDTH  LA data from user.
- la_iena_mprj  in  LA_WIDTH  per-bit LA input enable.
- la_data_in_mprj  out  LA_WIDTH  gated, registered LA data to management.
- user_irq_core  in  IRQ_COUNT  raw user IRQs, asynchronous.
- user_irq_ena  in  IRQ_COUNT  per-line IRQ enable.
- user_irq  out  IRQ_COUNT  synchronised, gated IRQs.
- wb_timeout_flag  out  1  sticky timeout status.
- wb_timeout_clr  in  1  clears wb_timeout_flag.

Behaviour:
- Reset: asynchronous, active-high. While caravel_rst is high:
  - FSM goes to IDLE; timeout counter is 0.
  - mprj_ack_i_core=0, mprj_dat_i_core=0, mprj_cyc/stb_o_user=0.
  - la_data_in_mprj=0, user_irq=0, all sync flops 0, wb_timeout_flag=0.
- Reset mid-transaction aborts it: no ack is issued, and user cyc/stb drop immediately.
- LA path: la_data_in_mprj <= la_data_out_core & la_iena_mprj, per bit, one cycle latency.
- IRQ path:
  - Each line passes through SYNC_STAGES flops.
  - user_irq <= last sync stage & user_irq_ena (registered).
  - Latency from a raw edge to user_irq is SYNC_STAGES+1 cycles.
  - Deasserting an enable forces that output to 0 on the next edge.
- Wishbone pass-through: we/sel/adr/dat_o_user are combinational copies of the core signals. cyc_o_user and stb_o_user are both the registered decode of state==FWD.
- FSM states IDLE, FWD, ACK:
  - IDLE, cyc&stb and mprj_iena_wb=1: go to FWD and clear the counter.
  - IDLE, cyc&stb and mprj_iena_wb=0: go to ACK with dat_i_core=0. The disabled ack arrives 1 cycle after the request.
  - FWD, mprj_ack_i_user=1: capture dat_i_user, go to ACK. Core ack arrives 1 cycle after the user ack.
  - FWD, no ack and counter==WB_TIMEOUT-1: capture TIMEOUT_DATA, set wb_timeout_flag, go to ACK.
  - FWD otherwise: increment the counter.
  - FWD, core drops cyc (abort): go to IDLE, no ack.
  - ACK: mprj_ack_i_core=1 for exactly one cycle, then IDLE. The read data register holds its value until the next capture.
- Enable sampling: mprj_iena_wb is sampled only in IDLE. A change during FWD does not affect the transaction in progress.
- A user ack seen in IDLE or ACK is ignored.
- Simultaneous events:
  - User ack in the expiry cycle: the user ack wins, no flag.
  - Flag set and wb_timeout_clr in the same cycle: set wins.
- Counter width is clog2(WB_TIMEOUT+1). It never wraps, because it is cleared on FWD entry.

Decomposition:
- Package mgmt_protect_pkg holds:
  - the FSM state enum wb_guard_state_t (IDLE, FWD, ACK);
  - the default TIMEOUT_DATA constant;
  - a clog2 helper function.
- One sub-module, mgmt_sync_bit: a parametrised SYNC_STAGES flop chain with async active-high reset. It is instantiated IRQ_COUNT times.

Test Plan:
- Reset with random inputs held high -> all outputs 0. After reset release with la_data_out_core=all-ones and la_iena_mprj=64'h00FF_0000_0000_FFFF -> la_data_in_mprj=64'h00FF_0000_0000_FFFF one cycle later.
- Enabled read; user acks 3 cycles after stb_o_user rises with data 32'h1234_5678 -> ack_i_core pulses exactly 1 cycle, one cycle after the user ack; dat_i_core=32'h1234_5678; flag stays 0.
- Enabled read, user never acks, WB_TIMEOUT=8 -> stb_o_user high for 8 cycles, then ack_i_core with 32'hDEADBEEF and wb_timeout_flag=1. wb_timeout_clr pulse -> flag returns to 0.
- mprj_iena_wb=0, write request -> cyc/stb_o_user stay 0; ack_i_core is asserted 1 cycle after the request with data 0.
- user_irq_core[1] rises asynchronously with ena=3'b010 -> user_irq=3'b010 after 3 cycles (SYNC_STAGES=2). ena drops -> user_irq=0 next cycle.
- User ack in the expiry cycle plus reset asserted mid-FWD in a second transaction -> first transaction returns user data with no flag; second has no ack and user cyc/stb at 0 immediately.
